// File: rtl/z80_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// z80_bus_arbiter_pkg
// Shared definitions for the z80 / DMA RAM arbiter:
//   state_t   - arbiter FSM states (2-bit)
//   SEL_CPU / SEL_DMA - RAM mux select encodings
//   sat_inc8 / sat_dec8 - 8-bit saturating counter helpers
// ---------------------------------------------------------------------------
package z80_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_STOP   = 2'd1,
        ST_DMA    = 2'd2,
        ST_REFILL = 2'd3
    } state_t;

    localparam logic SEL_CPU = 1'b1;
    localparam logic SEL_DMA = 1'b0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec8(input logic [7:0] v);
        return (v == 8'h00) ? v : v - 8'd1;
    endfunction

endpackage

// File: rtl/z80_bus_arbiter.sv
// ---------------------------------------------------------------------------
// z80_bus_arbiter
// Shares a single-port RAM between the z80 core and one DMA master.
// The core is frozen through o_cpu_hold (1 = run) while DMA owns the bus.
// DMA bursts are bounded by MAX_BURST accesses, and after every burst the
// core is guaranteed MIN_CPU run cycles before the next grant.
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_cpu_a/_do/_w            core address / write data / write strobe
//   o_cpu_hold, o_cpu_di      core run enable, read data (= i_mem_di)
//   i_dma_req/_a/_do/_w       DMA request, address, write data, strobe
//   o_dma_gnt, o_dma_ack      bus owned by DMA, read data valid
//   o_dma_di                  read data to DMA
//   o_mem_a/_do/_w, i_mem_di  RAM port (1-cycle read latency)
// ---------------------------------------------------------------------------
module z80_bus_arbiter
    import z80_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned MIN_CPU   = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_cpu_a,
    input  logic [7:0]  i_cpu_do,
    input  logic        i_cpu_w,
    output logic        o_cpu_hold,
    output logic [7:0]  o_cpu_di,
    input  logic        i_dma_req,
    input  logic [15:0] i_dma_a,
    input  logic [7:0]  i_dma_do,
    input  logic        i_dma_w,
    output logic        o_dma_gnt,
    output logic        o_dma_ack,
    output logic [7:0]  o_dma_di,
    output logic [15:0] o_mem_a,
    output logic [7:0]  o_mem_do,
    output logic        o_mem_w,
    input  logic [7:0]  i_mem_di
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
    localparam logic [7:0] MIN_CPU_C   = 8'(MIN_CPU);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_burst_cnt;
    logic [7:0]  r_quota_cnt;
    logic        r_rd_pending;
    logic        w_sel;
    logic        w_dma_access;
    logic [7:0]  w_burst_inc;

    // A DMA access happens on every granted cycle where the master requests.
    assign w_dma_access = (r_state == ST_DMA) && i_dma_req;
    assign w_burst_inc  = sat_inc8(r_burst_cnt);

    // ---------------- state register ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_CPU;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            // A CPU write in progress is never interrupted.
            ST_CPU:    if (i_dma_req && (r_quota_cnt == 8'd0) && !i_cpu_w)
                           w_state_next = ST_STOP;
            ST_STOP:   w_state_next = ST_DMA;
            ST_DMA:    if (!i_dma_req || (w_burst_inc == MAX_BURST_C))
                           w_state_next = ST_REFILL;
            ST_REFILL: w_state_next = ST_CPU;
            default:   w_state_next = ST_CPU;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        w_sel      = SEL_CPU;
        o_cpu_hold = 1'b0;
        o_dma_gnt  = 1'b0;
        case (r_state)
            ST_CPU:    o_cpu_hold = 1'b1;
            ST_DMA: begin
                w_sel     = SEL_DMA;
                o_dma_gnt = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- counters and read-ack tracking ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_burst_cnt  <= 8'd0;
            r_quota_cnt  <= 8'd0;
            r_rd_pending <= 1'b0;
        end else begin
            // RAM data for a granted read appears one cycle later, possibly
            // while already in REFILL.
            r_rd_pending <= w_dma_access && !i_dma_w;
            case (r_state)
                ST_CPU:    r_quota_cnt <= sat_dec8(r_quota_cnt);
                ST_STOP:   r_burst_cnt <= 8'd0;
                ST_DMA:    if (w_dma_access) r_burst_cnt <= w_burst_inc;
                ST_REFILL: r_quota_cnt <= MIN_CPU_C;
                default: ;
            endcase
        end
    end

    // ---------------- RAM mux ----------------
    // In STOP and REFILL the frozen core address stays on the bus so that its
    // read data is valid on o_cpu_di when the core resumes.
    assign o_mem_a   = (w_sel == SEL_CPU) ? i_cpu_a  : i_dma_a;
    assign o_mem_do  = (w_sel == SEL_CPU) ? i_cpu_do : i_dma_do;
    assign o_mem_w   = (w_sel == SEL_CPU) ? i_cpu_w  : (i_dma_w & i_dma_req);
    assign o_cpu_di  = i_mem_di;
    assign o_dma_di  = i_mem_di;
    assign o_dma_ack = r_rd_pending;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
module tb_z80_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    // instance 1: MAX_BURST=16, MIN_CPU=8
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_w;
    logic        cpu_hold;
    logic [7:0]  cpu_di;
    logic        dma_req;
    logic [15:0] dma_a;
    logic [7:0]  dma_do;
    logic        dma_w;
    logic        dma_gnt;
    logic        dma_ack;
    logic [7:0]  dma_di;
    logic [15:0] mem_a;
    logic [7:0]  mem_do;
    logic        mem_w;
    logic [7:0]  mem_di;
    // instance 2: MAX_BURST=1, MIN_CPU=0
    logic        cpu_hold2;
    logic [7:0]  cpu_di2;
    logic        dma_req2;
    logic        dma_gnt2;
    logic        dma_ack2;
    logic [7:0]  dma_di2;
    logic [15:0] mem_a2;
    logic [7:0]  mem_do2;
    logic        mem_w2;
    logic [7:0]  mem_di2;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:65535];

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // single-port RAM, read-before-write, 1-cycle latency
    always @(posedge clk) begin
        if (mem_w) ram[mem_a] <= mem_do;
        mem_di <= ram[mem_a];
    end

    always @(posedge clk) mem_di2 <= mem_a2[7:0];

    z80_bus_arbiter #(.MAX_BURST(16), .MIN_CPU(8)) u_dut (
        .i_clock(clk), .i_reset(rst),
        .i_cpu_a(cpu_a), .i_cpu_do(cpu_do), .i_cpu_w(cpu_w),
        .o_cpu_hold(cpu_hold), .o_cpu_di(cpu_di),
        .i_dma_req(dma_req), .i_dma_a(dma_a), .i_dma_do(dma_do), .i_dma_w(dma_w),
        .o_dma_gnt(dma_gnt), .o_dma_ack(dma_ack), .o_dma_di(dma_di),
        .o_mem_a(mem_a), .o_mem_do(mem_do), .o_mem_w(mem_w), .i_mem_di(mem_di)
    );

    z80_bus_arbiter #(.MAX_BURST(1), .MIN_CPU(0)) u_dut2 (
        .i_clock(clk), .i_reset(rst),
        .i_cpu_a(16'h1111), .i_cpu_do(8'h00), .i_cpu_w(1'b0),
        .o_cpu_hold(cpu_hold2), .o_cpu_di(cpu_di2),
        .i_dma_req(dma_req2), .i_dma_a(16'h2222), .i_dma_do(8'h00), .i_dma_w(1'b0),
        .o_dma_gnt(dma_gnt2), .o_dma_ack(dma_ack2), .o_dma_di(dma_di2),
        .o_mem_a(mem_a2), .o_mem_do(mem_do2), .o_mem_w(mem_w2), .i_mem_di(mem_di2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_a = 16'h1234; cpu_do = 8'h00; cpu_w = 1'b0;
        dma_req = 1'b0; dma_a = 16'h0000; dma_do = 8'h00; dma_w = 1'b0; dma_req2 = 1'b0;
        tick(); tick();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold got %b exp 1", cpu_hold); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", dma_gnt); end
        checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", dma_ack); end
        checks++; if (mem_a !== 16'h1234) begin errors++; $display("FAIL reset_mem_a got %h exp 1234", mem_a); end
        checks++; if (cpu_hold2 !== 1'b1) begin errors++; $display("FAIL reset_hold2 got %b exp 1", cpu_hold2); end
        rst = 1'b0;
        tick();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL post_reset_hold got %b exp 1", cpu_hold); end
        $display("test_reset done");
    endtask

    task automatic test_cpu_reads();
        for (int i = 0; i < 100; i++) begin
            cpu_a = 16'(i);
            #1;
            checks++; if (mem_a !== 16'(i)) begin errors++; $display("FAIL cpu_mem_a got %h exp %h", mem_a, 16'(i)); end
            tick();
            checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL cpu_hold cyc %0d got %b exp 1", i, cpu_hold); end
            checks++; if (cpu_di !== init_val(16'(i))) begin errors++; $display("FAIL cpu_di addr %h got %h exp %h", 16'(i), cpu_di, init_val(16'(i))); end
        end
        $display("test_cpu_reads done");
    endtask

    task automatic test_dma_burst();
        logic        adv;
        logic        exp_hold;
        logic [15:0] ack_addr;
        int          ack_cnt;
        int          acc_cnt;
        cpu_a = 16'h0100; cpu_w = 1'b0;
        dma_a = 16'h4000; dma_w = 1'b0; dma_req = 1'b1;
        adv = 1'b0; ack_addr = 16'h4000; ack_cnt = 0; acc_cnt = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(posedge clk); #1;
            if (adv) begin
                dma_a = dma_a + 16'd1;
                if (dma_a == 16'h4014) dma_req = 1'b0;
            end
            // expected: STOP+16 DMA+REFILL (0..17), 9 CPU, STOP+5 DMA+REFILL (27..33)
            exp_hold = !((cyc <= 17) || (cyc >= 27 && cyc <= 33));
            checks++; if (cpu_hold !== exp_hold) begin errors++; $display("FAIL burst_hold cyc %0d got %b exp %b", cyc, cpu_hold, exp_hold); end
            if (cyc == 18) begin
                checks++; if (cpu_di !== init_val(16'h0100)) begin errors++; $display("FAIL resume_cpu_di got %h exp %h", cpu_di, init_val(16'h0100)); end
            end
            if (dma_ack === 1'b1) begin
                checks++; if (dma_di !== init_val(ack_addr)) begin errors++; $display("FAIL dma_di addr %h got %h exp %h", ack_addr, dma_di, init_val(ack_addr)); end
                ack_addr = ack_addr + 16'd1;
                ack_cnt++;
            end
            adv = dma_gnt && dma_req;
            if (adv) acc_cnt++;
        end
        checks++; if (ack_cnt != 20) begin errors++; $display("FAIL burst_ack_count got %0d exp 20", ack_cnt); end
        checks++; if (acc_cnt != 20) begin errors++; $display("FAIL burst_access_count got %0d exp 20", acc_cnt); end
        $display("test_dma_burst done: %0d accesses, %0d acks", acc_cnt, ack_cnt);
    endtask

    task automatic test_cpu_write_first();
        cpu_a = 16'h8000; cpu_do = 8'h55; cpu_w = 1'b1;
        dma_a = 16'h5000; dma_w = 1'b0; dma_req = 1'b1;
        #1;
        checks++; if (mem_w !== 1'b1 || mem_a !== 16'h8000 || mem_do !== 8'h55) begin errors++; $display("FAIL cpu_write_bus got w=%b a=%h d=%h exp 1/8000/55", mem_w, mem_a, mem_do); end
        tick();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL write_hold1 got %b exp 1", cpu_hold); end
        tick();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL write_hold2 got %b exp 1", cpu_hold); end
        cpu_w = 1'b0;
        tick();  // STOP
        checks++; if (cpu_hold !== 1'b0 || dma_gnt !== 1'b0) begin errors++; $display("FAIL stop_state got hold=%b gnt=%b exp 0/0", cpu_hold, dma_gnt); end
        checks++; if (cpu_di !== 8'h55) begin errors++; $display("FAIL write_landed got %h exp 55", cpu_di); end
        dma_req = 1'b0;
        tick();  // DMA with zero accesses
        checks++; if (dma_gnt !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL empty_dma got gnt=%b hold=%b exp 1/0", dma_gnt, cpu_hold); end
        tick();  // REFILL
        checks++; if (dma_gnt !== 1'b0 || cpu_hold !== 1'b0 || dma_ack !== 1'b0) begin errors++; $display("FAIL empty_refill got gnt=%b hold=%b ack=%b exp 0/0/0", dma_gnt, cpu_hold, dma_ack); end
        tick();  // CPU
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL empty_resume got %b exp 1", cpu_hold); end
        $display("test_cpu_write_first done");
    endtask

    task automatic test_dma_write();
        repeat (12) tick();
        cpu_a = 16'h9000; cpu_w = 1'b0;
        dma_a = 16'h9000; dma_do = 8'hAA; dma_w = 1'b1; dma_req = 1'b1;
        tick();  // STOP
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL dw_stop_hold got %b exp 0", cpu_hold); end
        checks++; if (cpu_di !== 8'hCA) begin errors++; $display("FAIL dw_prefreeze got %h exp ca", cpu_di); end
        tick();  // DMA
        checks++; if (dma_gnt !== 1'b1 || mem_w !== 1'b1 || mem_a !== 16'h9000 || mem_do !== 8'hAA) begin errors++; $display("FAIL dw_bus got gnt=%b w=%b a=%h d=%h exp 1/1/9000/aa", dma_gnt, mem_w, mem_a, mem_do); end
        tick();  // write landed, still DMA
        dma_req = 1'b0; dma_w = 1'b0;
        checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL dw_no_ack got %b exp 0", dma_ack); end
        tick();  // REFILL
        checks++; if (cpu_hold !== 1'b0 || dma_gnt !== 1'b0) begin errors++; $display("FAIL dw_refill got hold=%b gnt=%b exp 0/0", cpu_hold, dma_gnt); end
        tick();  // CPU
        checks++; if (cpu_hold !== 1'b1 || cpu_di !== 8'hAA) begin errors++; $display("FAIL dw_resume got hold=%b di=%h exp 1/aa", cpu_hold, cpu_di); end
        $display("test_dma_write done");
    endtask

    task automatic test_reset_mid_burst();
        repeat (12) tick();
        cpu_a = 16'h0200;
        dma_a = 16'h4000; dma_w = 1'b0; dma_req = 1'b1;
        tick();  // STOP
        tick();  // DMA
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt got %b exp 1", dma_gnt); end
        tick();  // first read done
        checks++; if (dma_ack !== 1'b1) begin errors++; $display("FAIL rm_first_ack got %b exp 1", dma_ack); end
        dma_a = 16'h4001;
        rst = 1'b1;
        tick();
        checks++; if (cpu_hold !== 1'b1 || dma_gnt !== 1'b0 || dma_ack !== 1'b0) begin errors++; $display("FAIL rm_reset got hold=%b gnt=%b ack=%b exp 1/0/0", cpu_hold, dma_gnt, dma_ack); end
        checks++; if (mem_a !== 16'h0200) begin errors++; $display("FAIL rm_mem_a got %h exp 0200", mem_a); end
        rst = 1'b0; dma_req = 1'b0;
        tick();
        checks++; if (dma_ack !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL rm_after got ack=%b hold=%b exp 0/1", dma_ack, cpu_hold); end
        $display("test_reset_mid_burst done");
    endtask

    task automatic test_back_to_back();
        int acc;
        logic eh, eg, ea;
        acc = 0;
        dma_req2 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            // STOP, DMA, REFILL, CPU repeating
            eh = ((k % 4) == 3);
            eg = ((k % 4) == 1);
            ea = ((k % 4) == 2);
            checks++; if (cpu_hold2 !== eh || dma_gnt2 !== eg || dma_ack2 !== ea) begin errors++; $display("FAIL b2b cyc %0d got hold=%b gnt=%b ack=%b exp %b/%b/%b", k, cpu_hold2, dma_gnt2, dma_ack2, eh, eg, ea); end
            if (dma_ack2 === 1'b1) begin
                checks++; if (dma_di2 !== 8'h22) begin errors++; $display("FAIL b2b_di got %h exp 22", dma_di2); end
            end
            if (dma_gnt2 && dma_req2) acc++;
        end
        checks++; if (acc != 4) begin errors++; $display("FAIL b2b_access_count got %0d exp 4", acc); end
        dma_req2 = 1'b0;
        $display("test_back_to_back done: %0d accesses in 16 cycles", acc);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = init_val(16'(a));
        test_reset();
        test_cpu_reads();
        test_dma_burst();
        test_cpu_write_first();
        test_dma_write();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
